arb_grant_xfer: RTL and testbench

- Downstream consumer of the 4-line fixed-priority arbiter's registered one-hot grant vector.
- On a valid grant, latches the winning requester as owner and moves a fixed-length burst of data beats from that requester to a single output channel with valid/ready handshake.
- Pulses a per-requester done at the end of the burst, so the requester drops its request.
- Flags illegal (multi-hot) grants.

---
 rtl/arb_pkg.sv | 48 ++++
 rtl/arb_grant_xfer_if.sv | 45 ++++
 rtl/arb_onehot_enc.sv | 32 +++
 rtl/arb_grant_xfer.sv | 216 +++++++++++++++++++++
 tb/tb_arb_grant_xfer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the fixed-priority arbiter family and its grant
// consumer (arb_grant_xfer).
//   N_REQ          : default number of requesters (arbiter width)
//   BURST_LEN_DEF  : default beats moved per granted transfer
//   idw_f()        : owner index width for a given requester count
//   state_t        : grant-consumer FSM states
//   is_onehot()    : true when exactly one bit of a vector is set
//   onehot_to_idx(): index of the highest set bit (the only one when one-hot)
// Vectors are passed zero-extended to 32 bits so the helpers serve any
// requester count up to 32.
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ         = 4;
  localparam int BURST_LEN_DEF = 4;

  // Owner index width; a single requester still gets a 1-bit index.
  function automatic int idw_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // v & (v-1) clears the lowest set bit; a one-hot vector becomes zero.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic logic [7:0] onehot_to_idx(input logic [31:0] v);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        idx = 8'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_grant_xfer_if.sv
// -----------------------------------------------------------------------------
// arb_grant_xfer_if
// Bundles the grant input, the per-requester beat sources and the output beat
// channel of arb_grant_xfer.
//   grant      : one-hot grant from the arbiter (0 = none)
//   req_valid  : per-requester beat available
//   req_data   : per-requester beat data, lane i at [i*DW +: DW]
//   req_pop    : one-hot beat-consumed strobe to the owner
//   out_*      : output beat channel (valid/ready), source index, last flag
//   done       : one-cycle one-hot burst-complete pulse
//   busy       : transfer in progress
//   grant_err  : sticky multi-hot grant flag
// slave  : the transfer engine side
// master : the environment side (arbiter, requesters, downstream sink)
// -----------------------------------------------------------------------------
interface arb_grant_xfer_if #(
  parameter int N   = 4,
  parameter int DW  = 8,
  parameter int IDW = 2
);

  logic [N-1:0]    grant;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_pop;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IDW-1:0]  out_src;
  logic            out_last;
  logic [N-1:0]    done;
  logic            busy;
  logic            grant_err;

  modport slave (
    input  grant, req_valid, req_data, out_ready,
    output req_pop, out_valid, out_data, out_src, out_last, done, busy, grant_err
  );

  modport master (
    output grant, req_valid, req_data, out_ready,
    input  req_pop, out_valid, out_data, out_src, out_last, done, busy, grant_err
  );

endinterface

// File: rtl/arb_onehot_enc.sv
// -----------------------------------------------------------------------------
// arb_onehot_enc
// Combinational classification of the arbiter grant vector.
//   grant  (in)  : grant vector, N bits
//   idx    (out) : index of the granted requester (meaningful when onehot=1)
//   onehot (out) : exactly one grant bit set
//   multi  (out) : more than one grant bit set (illegal grant)
// grant=0 gives onehot=0 and multi=0.
// -----------------------------------------------------------------------------
module arb_onehot_enc
  import arb_pkg::*;
#(
  parameter int N   = N_REQ,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           onehot,
  output logic           multi
);

  logic [31:0] grant_ext_s;

  // Classify the grant and encode the winner index
  always_comb begin
    grant_ext_s = 32'(grant);
    onehot      = is_onehot(grant_ext_s);
    multi       = (grant_ext_s != 32'd0) && !onehot;
    idx         = IDW'(onehot_to_idx(grant_ext_s));
  end

endmodule

// File: rtl/arb_grant_xfer.sv
// -----------------------------------------------------------------------------
// arb_grant_xfer
// Consumer of the fixed-priority arbiter's registered one-hot grant. On a
// legal grant in IDLE it latches the winner as owner and moves BURST_LEN
// beats from that requester's lane to a single valid/ready output channel,
// then pulses done[owner] for one cycle so the requester can drop its request.
// Multi-hot grants seen in IDLE set a sticky grant_err and are not served.
//
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   bus.grant      : one-hot grant, ignored outside IDLE
//   bus.req_valid  : per-requester beat available
//   bus.req_data   : per-requester beat data, lane i at [i*DW +: DW]
//   bus.req_pop    : combinational one-hot pop to the owner when a beat loads
//   bus.out_valid  : registered output beat valid
//   bus.out_ready  : downstream ready
//   bus.out_data   : registered output beat
//   bus.out_src    : registered owner index of the current beat
//   bus.out_last   : registered final-beat marker
//   bus.done       : registered one-cycle one-hot burst-complete pulse
//   bus.busy       : high in XFER and DONE
//   bus.grant_err  : sticky multi-hot grant flag, cleared only by reset
// -----------------------------------------------------------------------------
module arb_grant_xfer
  import arb_pkg::*;
#(
  parameter int N         = N_REQ,
  parameter int DW        = 8,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input logic             clk,
  input logic             rst_n,
  arb_grant_xfer_if.slave bus
);

  localparam int         IDW     = idw_f(N);
  localparam logic [7:0] BL_C    = 8'(BURST_LEN);
  localparam logic [7:0] BL_M1_C = 8'(BURST_LEN - 1);

  state_t          state_r;
  state_t          state_next_s;

  logic [IDW-1:0]  owner_r;
  logic [7:0]      ld_cnt_r;     // beats loaded into the output register
  logic [7:0]      tx_cnt_r;     // beats accepted downstream

  logic            out_valid_r;
  logic [DW-1:0]   out_data_r;
  logic [IDW-1:0]  out_src_r;
  logic            out_last_r;
  logic [N-1:0]    done_r;
  logic [N-1:0]    done_next_s;
  logic            grant_err_r;

  logic [IDW-1:0]  enc_idx_s;
  logic            enc_onehot_s;
  logic            enc_multi_s;

  logic            load_s;
  logic            accept_s;
  logic [N-1:0]    req_pop_s;
  logic [DW-1:0]   lane_s [N];

  arb_onehot_enc #(
    .N   (N),
    .IDW (IDW)
  ) u_enc (
    .grant  (bus.grant),
    .idx    (enc_idx_s),
    .onehot (enc_onehot_s),
    .multi  (enc_multi_s)
  );

  // Split the flat request data bus into per-requester lanes
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane_s[i] = bus.req_data[i*DW +: DW];
    end
  end

  // Beat load / accept strobes and the owner pop
  // A slot is free when the output register is empty or its beat leaves
  // this cycle, which gives one beat per cycle under continuous ready.
  always_comb begin
    load_s    = 1'b0;
    accept_s  = 1'b0;
    req_pop_s = {N{1'b0}};
    if (state_r == XFER) begin
      load_s   = bus.req_valid[owner_r] && (ld_cnt_r < BL_C) &&
                 (!out_valid_r || bus.out_ready);
      accept_s = out_valid_r && bus.out_ready;
      if (load_s) begin
        req_pop_s[owner_r] = 1'b1;
      end else begin
        req_pop_s = {N{1'b0}};
      end
    end else begin
      load_s    = 1'b0;
      accept_s  = 1'b0;
      req_pop_s = {N{1'b0}};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; the burst ends when the final beat is accepted
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enc_onehot_s) begin
          state_next_s = XFER;
        end else begin
          state_next_s = IDLE;
        end
      end
      XFER: begin
        if (accept_s && (tx_cnt_r == BL_M1_C)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = XFER;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Done pulse is registered so it lines up with the single DONE cycle
  always_comb begin
    done_next_s = {N{1'b0}};
    if ((state_r == XFER) && (state_next_s == DONE)) begin
      done_next_s[owner_r] = 1'b1;
    end else begin
      done_next_s = {N{1'b0}};
    end
  end

  // Owner capture, beat counters and the output beat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r     <= {IDW{1'b0}};
      ld_cnt_r    <= 8'd0;
      tx_cnt_r    <= 8'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_src_r   <= {IDW{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (enc_onehot_s) begin
            owner_r  <= enc_idx_s;
            ld_cnt_r <= 8'd0;
            tx_cnt_r <= 8'd0;
          end
        end
        XFER: begin
          if (accept_s) begin
            tx_cnt_r <= tx_cnt_r + 8'd1;
          end
          // Without a load the beat register only changes when it drains,
          // so data/src/last stay put while the sink stalls.
          if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= lane_s[owner_r];
            out_src_r   <= owner_r;
            out_last_r  <= (ld_cnt_r == BL_M1_C);
            ld_cnt_r    <= ld_cnt_r + 8'd1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        DONE:    out_valid_r <= 1'b0;
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  // Burst-complete pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= {N{1'b0}};
    end else begin
      done_r <= done_next_s;
    end
  end

  // Sticky illegal-grant flag, only meaningful while waiting for a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_err_r <= 1'b0;
    end else if ((state_r == IDLE) && enc_multi_s) begin
      grant_err_r <= 1'b1;
    end
  end

  assign bus.req_pop   = req_pop_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.out_last  = out_last_r;
  assign bus.done      = done_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.grant_err = grant_err_r;

endmodule

// File: tb/tb_arb_grant_xfer.sv
// -----------------------------------------------------------------------------
// tb_arb_grant_xfer
// Drives arb_grant_xfer (BURST_LEN=4) through directed and randomized bursts
// and compares every cycle against a transaction-level reference model. A
// second instance with BURST_LEN=1 covers the single-beat burst.
// Requesters behave as counting sources: lane i shows base[i]+cnt[i] and
// advances whenever the DUT pops it.
// -----------------------------------------------------------------------------
module tb_arb_grant_xfer;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int BL  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main DUT stimulus
  logic [N-1:0] grant_v = '0;
  logic [N-1:0] rv = '0;
  logic         rdy = 1'b0;
  logic [7:0]   base [N];
  logic [7:0]   cnt8 [N];

  arb_grant_xfer_if #(.N(N), .DW(DW), .IDW(IDW)) bus ();
  arb_grant_xfer #(.N(N), .DW(DW), .BURST_LEN(BL)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.grant     = grant_v;
  assign bus.req_valid = rv;
  assign bus.out_ready = rdy;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW] = base[i] + cnt8[i];
    end
  end

  // Single-beat instance
  logic [N-1:0] g1 = '0;
  logic [N-1:0] rv1 = '0;
  logic         rdy1 = 1'b0;

  arb_grant_xfer_if #(.N(N), .DW(DW), .IDW(IDW)) bus1 ();
  arb_grant_xfer #(.N(N), .DW(DW), .BURST_LEN(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus1.grant     = g1;
  assign bus1.req_valid = rv1;
  assign bus1.out_ready = rdy1;
  assign bus1.req_data  = 32'h0000_5C00;

  // Reference model: transaction phase and contents of the output slot
  int         m_phase = 0;      // 0 waiting for grant, 1 moving beats, 2 done cycle
  int         m_owner = 0;
  int         m_loaded = 0;
  int         m_sent = 0;
  bit         m_v = 1'b0;
  logic [7:0] m_d = 8'h00;
  bit         m_l = 1'b0;
  bit         m_err = 1'b0;
  int         obs_pop = 0;
  int         obs_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One clock: compare at the falling edge, advance the model, let the
  // sources react to the pop after the rising edge.
  task automatic cycle();
    bit ld, acc;
    logic [N-1:0] exp_pop, pop_seen;
    int ones, widx;
    @(negedge clk);
    chk("out_valid", bus.out_valid, m_v);
    if (m_v) begin
      chk("out_data", bus.out_data, m_d);
      chk("out_src", bus.out_src, m_owner);
      chk("out_last", bus.out_last, m_l);
    end
    chk("busy", bus.busy, (m_phase != 0));
    chk("done", bus.done, (m_phase == 2) ? bit_of(m_owner) : '0);
    chk("grant_err", bus.grant_err, m_err);
    ld  = (m_phase == 1) && rv[m_owner] && (m_loaded < BL) && (!m_v || rdy);
    acc = (m_phase == 1) && m_v && rdy;
    exp_pop = ld ? bit_of(m_owner) : '0;
    chk("req_pop", bus.req_pop, exp_pop);
    pop_seen = bus.req_pop;
    if (bus.req_pop != '0) obs_pop++;
    if (bus.out_valid && rdy) obs_acc++;
    case (m_phase)
      0: begin
        ones = $countones(grant_v);
        if (ones == 1) begin
          widx = 0;
          for (int i = 0; i < N; i++) if (grant_v[i]) widx = i;
          m_phase = 1; m_owner = widx; m_loaded = 0; m_sent = 0;
          obs_pop = 0; obs_acc = 0;
        end else if (ones > 1) begin
          m_err = 1'b1;
        end
      end
      1: begin
        if (acc) m_sent++;
        if (ld) begin
          m_v = 1'b1;
          m_d = base[m_owner] + cnt8[m_owner];
          m_l = (m_loaded == BL - 1);
          m_loaded++;
        end else if (rdy) begin
          m_v = 1'b0;
        end
        if (acc && m_sent == BL) m_phase = 2;
      end
      default: begin
        chk("burst_pops", obs_pop, BL);
        chk("burst_accepts", obs_acc, BL);
        m_phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pop_seen[i]) cnt8[i] = cnt8[i] + 8'd1;
  endtask

  // One burst for 'owner'. ready_mode: 0 always, 1 pattern 1,0,0,1, 2 random.
  // stall_at: first of three cycles with the owner's valid low (-1 = none).
  // mid_grant: grant driven from cycle 2 on and kept after done.
  task automatic burst(input int owner, input int ready_mode, input int stall_at,
                       input logic [N-1:0] mid_grant, input bit rv_rand);
    int n, ph;
    bit fin;
    n = 0; fin = 1'b0;
    base[owner] = 8'($urandom);
    cnt8[owner] = 8'h00;
    grant_v = bit_of(owner);
    rv = bit_of(owner);
    while (!fin && n < 200) begin
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ((n % 4) == 0) || ((n % 4) == 3);
        default: rdy = 1'($urandom);
      endcase
      if (m_phase == 1) begin
        if (stall_at >= 0 && n >= stall_at && n < stall_at + 3) rv[owner] = 1'b0;
        else if (rv_rand) rv[owner] = (($urandom % 4) != 0);
        else rv[owner] = 1'b1;
      end
      if (n == 2 && mid_grant != '0) begin
        grant_v = mid_grant;
        rv = rv | mid_grant;
      end
      ph = m_phase;
      cycle();
      n++;
      if (m_phase == 2) begin
        grant_v = mid_grant;
        rv = mid_grant;
      end
      if (ph == 2) fin = 1'b1;
    end
    checks++;
    assert (fin) else begin
      failures++;
      $error("FAIL burst_budget owner=%0d observed=timeout expected=done", owner);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      base[i] = 8'h00;
      cnt8[i] = 8'h00;
    end

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_out_src", bus.out_src, 2'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_done", bus.done, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_grant_err", bus.grant_err, 1'b0);
    chk("rst_req_pop", bus.req_pop, 4'b0000);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // BURST_LEN=1: single beat flagged last, then done
    g1 = 4'b0010; rv1 = 4'b0010; rdy1 = 1'b1;
    @(negedge clk);
    chk("bl1_idle_busy", bus1.busy, 1'b0);
    chk("bl1_idle_pop", bus1.req_pop, 4'b0000);
    @(posedge clk); #1;
    g1 = 4'b0000;
    @(negedge clk);
    chk("bl1_pop", bus1.req_pop, 4'b0010);
    chk("bl1_busy", bus1.busy, 1'b1);
    @(negedge clk);
    chk("bl1_valid", bus1.out_valid, 1'b1);
    chk("bl1_data", bus1.out_data, 8'h5C);
    chk("bl1_src", bus1.out_src, 2'd1);
    chk("bl1_last", bus1.out_last, 1'b1);
    chk("bl1_no_pop", bus1.req_pop, 4'b0000);
    @(negedge clk);
    chk("bl1_done", bus1.done, 4'b0010);
    chk("bl1_valid_off", bus1.out_valid, 1'b0);
    @(negedge clk);
    chk("bl1_idle_again", bus1.busy, 1'b0);
    chk("bl1_done_off", bus1.done, 4'b0000);
    @(posedge clk); #1;

    // Basic burst from requester 2 at full rate
    burst(2, 0, -1, 4'b0000, 1'b0);
    // Backpressure on requester 0
    burst(0, 1, -1, 4'b0000, 1'b0);
    // Grant moves to requester 3 mid-burst; served only after done[0]
    burst(0, 0, -1, 4'b1000, 1'b0);
    burst(3, 0, -1, 4'b0000, 1'b0);

    // Multi-hot grant: sticky error, nothing served
    grant_v = 4'b0110; rv = 4'b0110; rdy = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    grant_v = 4'b0000; rv = 4'b0000;
    for (int k = 0; k < 2; k++) cycle();
    burst(1, 0, -1, 4'b0000, 1'b0);

    // Owner valid drops for three cycles mid-burst; data A0..A3 in order
    grant_v = 4'b0000;
    burst(0, 0, 3, 4'b0000, 1'b0);
    base[0] = 8'hA0; cnt8[0] = 8'h00;
    grant_v = 4'b0001; rv = 4'b0001; rdy = 1'b1;
    cycle();
    cycle();
    rv = 4'b0000;
    for (int k = 0; k < 3; k++) cycle();
    rv = 4'b0001;
    begin
      int n;
      n = 0;
      while (m_phase != 2 && n < 40) begin
        if (m_phase == 1) grant_v = 4'b0000;
        cycle();
        n++;
      end
      rv = 4'b0000;
      cycle();
      chk("resume_lane0_count", cnt8[0], 8'd4);
    end

    // Randomized bursts with random ready, valid gaps and grant noise
    for (int r = 0; r < 10; r++) begin
      burst(int'($urandom % N), 2, (($urandom % 2) != 0) ? int'($urandom % 6) : -1,
            4'($urandom), 1'b1);
    end

    // Asynchronous reset in the middle of a stalled burst
    grant_v = 4'b0001; rv = 4'b0001; rdy = 1'b0;
    cycle();
    cycle();
    cycle();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_data", bus.out_data, 8'h00);
    chk("arst_out_src", bus.out_src, 2'd0);
    chk("arst_out_last", bus.out_last, 1'b0);
    chk("arst_done", bus.done, 4'b0000);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_req_pop", bus.req_pop, 4'b0000);
    chk("arst_grant_err", bus.grant_err, 1'b0);
    grant_v = 4'b0000; rv = 4'b0000; rdy = 1'b1;
    m_phase = 0; m_v = 1'b0; m_err = 1'b0;
    #12 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
